// File: rtl/ray_sweep_ctrl_if.sv
// Bus bundle for ray_sweep_ctrl: memory read port, rayCastReg load ports and
// distance-buffer write port. master = sequencer side, slave = datapath/memory side.
interface ray_sweep_ctrl_if #(
  parameter int COL_W = 8
);
  logic             mem_rd_en;
  logic [15:0]      mem_addr;
  logic [15:0]      mem_rd_data;

  logic             rc_a_en;
  logic             rc_b_en;
  logic [15:0]      rc_a;
  logic [15:0]      rc_b;
  logic [2:0]       rc_ctrl_a;
  logic [2:0]       rc_ctrl_b;
  logic [15:0]      rc_distance;
  logic [15:0]      rc_uv;

  logic             buf_wr_en;
  logic [COL_W-1:0] buf_wr_addr;
  logic [15:0]      buf_wr_dist;
  logic [15:0]      buf_wr_uv;

  modport master (
    output mem_rd_en, mem_addr,
    input  mem_rd_data,
    output rc_a_en, rc_b_en, rc_a, rc_b, rc_ctrl_a, rc_ctrl_b,
    input  rc_distance, rc_uv,
    output buf_wr_en, buf_wr_addr, buf_wr_dist, buf_wr_uv
  );

  modport slave (
    input  mem_rd_en, mem_addr,
    output mem_rd_data,
    input  rc_a_en, rc_b_en, rc_a, rc_b, rc_ctrl_a, rc_ctrl_b,
    output rc_distance, rc_uv,
    input  buf_wr_en, buf_wr_addr, buf_wr_dist, buf_wr_uv
  );
endinterface

// File: rtl/ray_sweep_ctrl.sv
// Frame sweep sequencer for rayCastReg: per column fetch ray, stream walls, keep nearest hit.
// Optional RAY_SWEEP_PERF_EN adds a saturating sweep_cycles counter output.
module ray_sweep_ctrl #(
  parameter int NUM_COLS = 160,
  parameter int WCNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       player_x,
  input  logic [15:0]       player_y,
  input  logic [15:0]       ray_base,
  input  logic [15:0]       wall_base,
  input  logic [WCNT_W-1:0] wall_count,
  output logic              busy,
  output logic              done,
`ifdef RAY_SWEEP_PERF_EN
  output logic [31:0]       sweep_cycles,
`endif
  ray_sweep_ctrl_if.master  bus
);

  localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_P, S_FETCH_R, S_CAP_R, S_LOAD_R, S_FETCH_W, S_CAP_W,
    S_LOAD_WS, S_LOAD_WE, S_WAIT, S_CMP, S_WRITE, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          k_q, k_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [WCNT_W-1:0]   wall_q, wall_d;
  logic [WCNT_W-1:0]   wc_q, wc_d;
  logic [15:0]         px_q, px_d, py_q, py_d;
  logic [15:0]         ray_base_q, ray_base_d, wall_base_q, wall_base_d;
  logic [15:0]         dx_q, dx_d, dy_q, dy_d;
  logic [3:0][15:0]    w_q, w_d;
  logic [15:0]         best_dist_q, best_dist_d, best_uv_q, best_uv_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                buf_wr_en_q, buf_wr_en_d;
  logic [COL_W-1:0]    buf_wr_addr_q, buf_wr_addr_d;
  logic [15:0]         buf_wr_dist_q, buf_wr_dist_d, buf_wr_uv_q, buf_wr_uv_d;
  logic [15:0]         col_off, wall_off;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    col_d       = col_q;
    wall_d      = wall_q;
    wc_d        = wc_q;
    px_d        = px_q;
    py_d        = py_q;
    ray_base_d  = ray_base_q;
    wall_base_d = wall_base_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    w_d         = w_q;
    best_dist_d = best_dist_q;
    best_uv_d   = best_uv_q;
    busy_d      = busy_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          px_d        = player_x;
          py_d        = player_y;
          ray_base_d  = ray_base;
          wall_base_d = wall_base;
          wc_d        = wall_count;
          busy_d      = 1'b1;
          state_d     = S_LOAD_P;
        end
      end
      S_LOAD_P: begin
        k_d     = '0;
        state_d = S_FETCH_R;
      end
      S_FETCH_R: begin
        if (k_q[0]) begin
          dx_d    = bus.mem_rd_data;
          k_d     = '0;
          state_d = S_CAP_R;
        end else begin
          k_d = 2'd1;
        end
      end
      S_CAP_R: begin
        dy_d    = bus.mem_rd_data;
        state_d = S_LOAD_R;
      end
      S_LOAD_R: begin
        best_dist_d = 16'hFFFF;
        best_uv_d   = 16'h0000;
        wall_d      = '0;
        k_d         = '0;
        state_d     = (wc_q == '0) ? S_WRITE : S_FETCH_W;
      end
      S_FETCH_W: begin
        // Read data lags the strobe by one cycle, so word k-1 lands while k is issued.
        if (k_q != 2'd0) w_d[k_q - 2'd1] = bus.mem_rd_data;
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) state_d = S_CAP_W;
      end
      S_CAP_W: begin
        w_d[3]  = bus.mem_rd_data;
        state_d = S_LOAD_WS;
      end
      S_LOAD_WS: state_d = S_LOAD_WE;
      S_LOAD_WE: state_d = S_WAIT;
      S_WAIT:    state_d = S_CMP;
      S_CMP: begin
        if (bus.rc_distance < best_dist_q) begin
          best_dist_d = bus.rc_distance;
          best_uv_d   = bus.rc_uv;
        end
        wall_d  = wall_q + WCNT_W'(1);
        state_d = (wall_d == wc_q) ? S_WRITE : S_FETCH_W;
      end
      S_WRITE: begin
        k_d = '0;
        if (col_q == LAST_COL) begin
          state_d = S_DONE;
        end else begin
          col_d   = col_q + COL_W'(1);
          state_d = S_FETCH_R;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        col_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    done_d        = (state_d == S_DONE);
    buf_wr_en_d   = (state_d == S_WRITE);
    buf_wr_addr_d = buf_wr_en_d ? col_q       : '0;
    buf_wr_dist_d = buf_wr_en_d ? best_dist_d : 16'h0000;
    buf_wr_uv_d   = buf_wr_en_d ? best_uv_d   : 16'h0000;
  end

`ifdef RAY_SWEEP_PERF_EN
  logic [31:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (state_q == S_IDLE && start)       cyc_d = 32'd0;
    else if (busy_q && cyc_q != '1)       cyc_d = cyc_q + 32'd1;
  end

  assign sweep_cycles = cyc_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      k_q           <= '0;
      col_q         <= '0;
      wall_q        <= '0;
      wc_q          <= '0;
      px_q          <= '0;
      py_q          <= '0;
      ray_base_q    <= '0;
      wall_base_q   <= '0;
      dx_q          <= '0;
      dy_q          <= '0;
      w_q           <= '0;
      best_dist_q   <= 16'hFFFF;
      best_uv_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      buf_wr_en_q   <= 1'b0;
      buf_wr_addr_q <= '0;
      buf_wr_dist_q <= '0;
      buf_wr_uv_q   <= '0;
`ifdef RAY_SWEEP_PERF_EN
      cyc_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      col_q         <= col_d;
      wall_q        <= wall_d;
      wc_q          <= wc_d;
      px_q          <= px_d;
      py_q          <= py_d;
      ray_base_q    <= ray_base_d;
      wall_base_q   <= wall_base_d;
      dx_q          <= dx_d;
      dy_q          <= dy_d;
      w_q           <= w_d;
      best_dist_q   <= best_dist_d;
      best_uv_q     <= best_uv_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      buf_wr_en_q   <= buf_wr_en_d;
      buf_wr_addr_q <= buf_wr_addr_d;
      buf_wr_dist_q <= buf_wr_dist_d;
      buf_wr_uv_q   <= buf_wr_uv_d;
`ifdef RAY_SWEEP_PERF_EN
      cyc_q         <= cyc_d;
`endif
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign bus.buf_wr_en   = buf_wr_en_q;
  assign bus.buf_wr_addr = buf_wr_addr_q;
  assign bus.buf_wr_dist = buf_wr_dist_q;
  assign bus.buf_wr_uv   = buf_wr_uv_q;

  assign col_off  = 16'(col_q) << 1;
  assign wall_off = 16'(wall_q) << 2;

  // Datapath and memory strobes are decoded straight from state, zero elsewhere.
  always_comb begin
    bus.mem_rd_en = 1'b0;
    bus.mem_addr  = 16'h0000;
    bus.rc_a_en   = 1'b0;
    bus.rc_b_en   = 1'b0;
    bus.rc_a      = 16'h0000;
    bus.rc_b      = 16'h0000;
    bus.rc_ctrl_a = 3'b000;
    bus.rc_ctrl_b = 3'b000;
    case (state_q)
      S_FETCH_R: begin
        bus.mem_rd_en = 1'b1;
        bus.mem_addr  = ray_base_q + col_off + 16'(k_q);
      end
      S_FETCH_W: begin
        bus.mem_rd_en = 1'b1;
        bus.mem_addr  = wall_base_q + wall_off + 16'(k_q);
      end
      S_LOAD_P: begin
        bus.rc_a_en = 1'b1;
        bus.rc_b_en = 1'b1;
        bus.rc_a    = px_q;
        bus.rc_b    = py_q;
      end
      S_LOAD_R: begin
        bus.rc_a_en   = 1'b1;
        bus.rc_b_en   = 1'b1;
        bus.rc_ctrl_a = 3'b001;
        bus.rc_ctrl_b = 3'b001;
        bus.rc_a      = dx_q;
        bus.rc_b      = dy_q;
      end
      S_LOAD_WS: begin
        bus.rc_a_en   = 1'b1;
        bus.rc_b_en   = 1'b1;
        bus.rc_ctrl_a = 3'b010;
        bus.rc_ctrl_b = 3'b010;
        bus.rc_a      = w_q[0];
        bus.rc_b      = w_q[1];
      end
      S_LOAD_WE: begin
        bus.rc_a_en   = 1'b1;
        bus.rc_b_en   = 1'b1;
        bus.rc_ctrl_a = 3'b011;
        bus.rc_ctrl_b = 3'b011;
        bus.rc_a      = w_q[2];
        bus.rc_b      = w_q[3];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ray_sweep_ctrl.sv
// Bench for ray_sweep_ctrl (NUM_COLS=4): table-driven sweeps with a scoreboard of
// expected buffer writes, plus hand sequences for start re-pulse and mid-sweep reset.
module tb_ray_sweep_ctrl;

  localparam int NC = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] player_x = '0, player_y = '0, ray_base = '0, wall_base = '0;
  logic [7:0]  wall_count = '0;
  logic        busy, done;
`ifdef RAY_SWEEP_PERF_EN
  logic [31:0] sweep_cycles;
`endif

  ray_sweep_ctrl_if #(.COL_W(2)) bus();

  ray_sweep_ctrl #(.NUM_COLS(NC), .WCNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .player_x   (player_x),
    .player_y   (player_y),
    .ray_base   (ray_base),
    .wall_base  (wall_base),
    .wall_count (wall_count),
    .busy       (busy),
    .done       (done),
`ifdef RAY_SWEEP_PERF_EN
    .sweep_cycles (sweep_cycles),
`endif
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Memory: one-cycle read latency. Datapath: LOAD_WE words become distance/uv.
  logic [15:0] mem [0:65535];
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];
    if (bus.rc_a_en && bus.rc_ctrl_a == 3'b011) begin
      bus.rc_distance <= bus.rc_a;
      bus.rc_uv       <= bus.rc_b;
    end
  end

  typedef struct {
    int          wc;
    logic [15:0] rb, wb;
    logic [15:0] d0, d1, d2, u0, u1, u2, ld, lu;
    logic [15:0] exp_d, exp_u;
    int          exp_cyc;
  } vec_t;

  vec_t        vecs [6];
  int          checks = 0, errors = 0;
  logic [47:0] sb [$];
  logic [15:0] rd_log [$];
  logic [31:0] ws_log [$];
  int          ray_cnt, p_loads;
  logic [15:0] p_a, p_b, exp_px, exp_py;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: actual %h required %h", nm, act, exp_v);
    end
  endtask

  task automatic monitor();
    logic [47:0] e;
    logic [15:0] ex, ey;
    if (bus.mem_rd_en) rd_log.push_back(bus.mem_addr);
    if (bus.rc_a_en) begin
      case (bus.rc_ctrl_a)
        3'b000: begin p_loads++; p_a = bus.rc_a; p_b = bus.rc_b; end
        3'b001: begin
          ex = 16'h0D00 + 16'(ray_cnt);
          ey = 16'h0E00 + 16'(ray_cnt);
          chk("ray_load", {bus.rc_b_en, bus.rc_ctrl_b, bus.rc_a, bus.rc_b}, {1'b1, 3'b001, ex, ey});
          ray_cnt++;
        end
        3'b010: ws_log.push_back({bus.rc_a, bus.rc_b});
        default: ;
      endcase
    end
    if (bus.buf_wr_en) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: actual col %0d dist %h uv %h required no write",
                 bus.buf_wr_addr, bus.buf_wr_dist, bus.buf_wr_uv);
      end else begin
        e = sb.pop_front();
        chk("buf_write", {16'(bus.buf_wr_addr), bus.buf_wr_dist, bus.buf_wr_uv}, 64'(e));
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
  endtask

  task automatic setup_row(input int idx);
    vec_t v;
    logic [15:0] a, d, u;
    v = vecs[idx];
    exp_px     = 16'h1200 + 16'(idx);
    exp_py     = 16'h3400 + 16'(idx);
    player_x   = exp_px;
    player_y   = exp_py;
    ray_base   = v.rb;
    wall_base  = v.wb;
    wall_count = 8'(v.wc);
    for (int c = 0; c < NC; c++) begin
      a = v.rb + 16'(2 * c);
      mem[a] = 16'h0D00 + 16'(c);
      a = a + 16'd1;
      mem[a] = 16'h0E00 + 16'(c);
    end
    for (int w = 0; w < v.wc; w++) begin
      d = (w == 0) ? v.d0 : (w == 1) ? v.d1 : (w == 2) ? v.d2 : (w == v.wc - 1) ? v.ld : 16'hF000;
      u = (w == 0) ? v.u0 : (w == 1) ? v.u1 : (w == 2) ? v.u2 : (w == v.wc - 1) ? v.lu : 16'h0EEE;
      a = v.wb + 16'(4 * w);
      mem[a] = 16'hA000 + 16'(w); a = a + 16'd1;
      mem[a] = 16'hB000 + 16'(w); a = a + 16'd1;
      mem[a] = d;                 a = a + 16'd1;
      mem[a] = u;
    end
    sb.delete();
    for (int c = 0; c < NC; c++) sb.push_back({16'(c), v.exp_d, v.exp_u});
    rd_log.delete();
    ws_log.delete();
    ray_cnt = 0;
    p_loads = 0;
  endtask

  task automatic run_sweep(input int idx, input int repulse_at, input bit start_on_done);
    int n, busy_cnt, done_n;
    vec_t v;
    v = vecs[idx];
    setup_row(idx);
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1; busy_cnt = 0; done_n = 0;
    forever begin
      if (busy) busy_cnt++;
      if (done) begin done_n = n; break; end
      if (n >= v.exp_cyc + 20) break;
      if (repulse_at != 0 && n == repulse_at) begin start = 1'b1; player_x = 16'h9999; end
      if (repulse_at != 0 && n == repulse_at + 1) start = 1'b0;
      step();
      n++;
    end
    chk("done_cycle", 64'(done_n), 64'(v.exp_cyc));
    chk("busy_cycles", 64'(busy_cnt), 64'(v.exp_cyc));
    if (start_on_done) start = 1'b1;
    step();
    start = 1'b0;
    chk("idle_after_done", {busy, done}, 2'b00);
    step();
    chk("start_not_accepted", busy, 1'b0);
    chk("player_load_count", 64'(p_loads), 64'd1);
    chk("player_value", {p_a, p_b}, {exp_px, exp_py});
    chk("ray_load_count", 64'(ray_cnt), 64'(NC));
    chk("read_count", 64'(rd_log.size()), 64'(NC * (2 + 4 * v.wc)));
    chk("writes_left", 64'(sb.size()), 64'd0);
`ifdef RAY_SWEEP_PERF_EN
    chk("sweep_cycles", sweep_cycles, 64'(v.exp_cyc));
`endif
  endtask

  initial begin
    int n;
    //            wc   rb        wb        d0        d1        d2        u0      u1      u2      ld      lu      exp_d     exp_u   cyc
    vecs[0] = '{  1, 16'h0100, 16'h1000, 16'h0200, 16'h0000, 16'h0000, 16'h40, 16'h00, 16'h00, 16'h0, 16'h0, 16'h0200, 16'h0040, 58};
    vecs[1] = '{  3, 16'h0200, 16'h2000, 16'h0500, 16'h0300, 16'h0300, 16'h01, 16'h02, 16'h03, 16'h0, 16'h0, 16'h0300, 16'h0002, 130};
    vecs[2] = '{  0, 16'h0300, 16'h3000, 16'h0000, 16'h0000, 16'h0000, 16'h00, 16'h00, 16'h00, 16'h0, 16'h0, 16'hFFFF, 16'h0000, 22};
    vecs[3] = '{  2, 16'h0400, 16'h4000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h07, 16'h08, 16'h00, 16'h0, 16'h0, 16'hFFFF, 16'h0000, 94};
    vecs[4] = '{  3, 16'hFFFE, 16'h1000, 16'h0400, 16'h0100, 16'h0050, 16'h0A, 16'h0B, 16'h0C, 16'h0, 16'h0, 16'h0050, 16'h000C, 130};
    vecs[5] = '{255, 16'h0100, 16'h1000, 16'h0900, 16'h0900, 16'h0900, 16'h01, 16'h02, 16'h03, 16'h0800, 16'h0077, 16'h0800, 16'h0077, 9202};

    sb.delete();
    repeat (3) step();
    chk("reset_ctrl", {busy, done, bus.mem_rd_en, bus.rc_a_en, bus.rc_b_en, bus.buf_wr_en,
                       bus.rc_ctrl_a, bus.rc_ctrl_b}, 12'h000);
    chk("reset_data", {bus.mem_addr, bus.rc_a, bus.rc_b, bus.buf_wr_dist}, 64'h0);
    chk("reset_buf", {bus.buf_wr_uv, 14'h0, bus.buf_wr_addr}, 32'h0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 6; i++) begin
      run_sweep(i, 0, 1'b0);
      if (i == 4) begin
        chk("ray_wrap_rd0", rd_log[14], 16'h0000);
        chk("ray_wrap_rd1", rd_log[15], 16'h0001);
        for (int k = 0; k < 4; k++) chk("wall2_rd", rd_log[24 + k], 16'h1008 + 16'(k));
        chk("load_ws_c1w2", ws_log[5], {16'hA002, 16'hB002});
      end
    end

    // Re-pulse start mid-sweep with a new player_x, and again on the done cycle.
    run_sweep(0, 10, 1'b1);

    // Reset during CMP of column 2 (W=1: cycle 2 + 14*2 + 12 after accept).
    setup_row(0);
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    while (n < 42) begin step(); n++; end
    chk("writes_before_reset", 64'(sb.size()), 64'd2);
    reset = 1'b1;
    #1;
    chk("midreset_ctrl", {busy, done, bus.mem_rd_en, bus.rc_a_en, bus.rc_b_en, bus.buf_wr_en}, 6'h00);
    chk("midreset_data", {bus.mem_addr, bus.rc_a, bus.buf_wr_dist, bus.buf_wr_uv}, 64'h0);
    sb.delete();
    repeat (4) step();
    reset = 1'b0;
    repeat (30) step();
    chk("idle_after_reset", busy, 1'b0);
    run_sweep(0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
